fft_stage_sched: RTL and testbench
==================================

# fft_stage_sched

Stage scheduler for the iterative FFT datapath: it sequences each frame through STAGES passes of the shared butterfly. It sits between the serial-to-parallel converter, the input mux, the butterfly, the feedback register and the parallel-to-serial converter. It drives the mux select, the butterfly rotation (stage) index, the feedback-register load strobe and the output strobe. It also handles frames arriving while the datapath is busy.

## Interface
- STAGES, 3, butterfly passes per frame (≥1)
- ROT_W, 3, rotation bus width; must hold STAGES-1
- PIPE_LAT, 1, butterfly latency in cycles from input to output (≥1)
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- frame_rdy  in  1  single-cycle pulse from s_p: a full 136-bit frame is valid
- ovr_clr  in  1  synchronous clear of `overrun`
- frame_ack  out  1  pulse in the first cycle of stage 0 of each accepted frame
- mux_flag  out  1  1 = butterfly input from s_p, 0 = from feedback register
- rotation  out  ROT_W  current stage index to the butterfly
- reg_load  out  1  feedback-register capture strobe (demux to reg1)
- out_valid  out  1  final-stage result strobe to p_s
- busy  out  1  a frame is in flight
- overrun  out  1  sticky: a frame_rdy was dropped

## Operation
- FSM states: IDLE, ISSUE, WAIT. Counters: stage (0..STAGES-1) and lat (0..PIPE_LAT).
- IDLE:
  - All strobes 0; rotation = 0; busy = 0.
  - frame_rdy → ISSUE, stage = 0.
- ISSUE (stage cycle k = 0):
  - busy = 1; rotation = stage.
  - mux_flag = 1 when stage = 0, else 0.
  - frame_ack = 1 when stage = 0.
  - → WAIT, lat = 1.
- WAIT (k = 1..PIPE_LAT):
  - rotation and mux_flag are held at their ISSUE values.
  - When lat = PIPE_LAT:
    - stage < STAGES-1: reg_load = 1; → ISSUE with stage+1.
    - stage = STAGES-1: out_valid = 1; end of frame.
  - Otherwise lat increments.
- End of frame, next state:
  - ISSUE with stage 0 if frame_rdy = 1 in this same cycle, or a pending frame exists (see Configuration).
  - IDLE otherwise.
- reg_load and out_valid are never both 1. Each is at most one pulse per stage.
- frame_rdy at any busy cycle other than the end-of-frame cycle: pending slot if enabled and empty; otherwise dropped and overrun set.
- overrun clears only on ovr_clr or reset. If ovr_clr and a new drop occur in the same cycle, overrun = 1 (set wins).
- Reset mid-frame aborts immediately:
  - FSM → IDLE; pending slot cleared.
  - No partial strobe is emitted after rst_n rises.

## Timing
- All outputs are registered (Moore).
- Reset value of every output is 0, including rotation and overrun.
- frame_rdy in cycle t → frame_ack and mux_flag = 1 in cycle t+1.
- Each stage lasts PIPE_LAT+1 cycles.
- out_valid occurs in cycle t + STAGES·(PIPE_LAT+1).
- Defaults (STAGES = 3, PIPE_LAT = 1):
  - ISSUE at t+1, t+3, t+5 with rotation 0, 1, 2.
  - reg_load at t+2 and t+4.
  - out_valid at t+6.
- Back-to-back: frame_rdy coincident with out_valid gives the next ISSUE in the following cycle, with zero idle gap.
- Maximum sustained throughput is one frame per STAGES·(PIPE_LAT+1) cycles.

## Configuration
- FFT_SCHED_PENDING_EN defined:
  - One-deep pending slot. The first frame_rdy during a busy, non-final cycle is stored.
  - The stored frame starts (ISSUE, stage 0) in the cycle after out_valid.
  - A second arrival while the slot is full is dropped and sets overrun.
  - If frame_rdy coincides with out_valid while the slot is full, the pending frame starts first and the new frame_rdy is dropped with overrun.
- Undefined:
  - No slot; every busy, non-final-cycle frame_rdy is dropped and sets overrun.
  - The end-of-frame acceptance rule is unchanged.

## Test plan
- Reset release, then single frame_rdy at t=10 (defaults) → frame_ack/mux_flag at 11; rotation 0,0,1,1,2,2 over cycles 11–16; reg_load at 12 and 14; out_valid at 16; busy falls at 17.
- frame_rdy at 16, coincident with out_valid → second frame_ack at 17, no idle cycle, overrun stays 0.
- frame_rdy at 10 and 13:
  - With FFT_SCHED_PENDING_EN: second frame_ack at 17, overrun = 0.
  - Without: no second frame, overrun = 1 from cycle 14.
- With FFT_SCHED_PENDING_EN, frame_rdy at 10, 12 and 14 → third frame dropped, overrun = 1; ovr_clr at 20 → overrun = 0 at 21.
- rst_n asserted at cycle 13 mid-stage-1 and released at 15 → all outputs 0 from 13; no reg_load/out_valid until a new frame_rdy.
- STAGES=4, PIPE_LAT=2, frame_rdy at 0 → ISSUE at 1, 4, 7, 10; reg_load at 3, 6, 9; out_valid at 12.

Source files
------------

// File: rtl/fft_stage_sched_if.sv
// fft_stage_sched_if: frame handshake and butterfly control bundle for fft_stage_sched.
interface fft_stage_sched_if #(parameter int ROT_W = 3) ();
  logic frame_rdy;
  logic ovr_clr;
  logic frame_ack;
  logic mux_flag;
  logic [ROT_W-1:0] rotation;
  logic reg_load;
  logic out_valid;
  logic busy;
  logic overrun;
  modport master (output frame_rdy, ovr_clr, input frame_ack, mux_flag, rotation, reg_load, out_valid, busy, overrun);
  modport slave (input frame_rdy, ovr_clr, output frame_ack, mux_flag, rotation, reg_load, out_valid, busy, overrun);
endinterface

// File: rtl/fft_stage_sched.sv
// fft_stage_sched: sequences each frame through STAGES butterfly passes with registered strobes.
// Define FFT_SCHED_PENDING_EN to add a one-deep slot for frames arriving mid-frame.
module fft_stage_sched #(
  parameter int STAGES   = 3,
  parameter int ROT_W    = 3,
  parameter int PIPE_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  fft_stage_sched_if.slave bus
);
  localparam int LW = $clog2(PIPE_LAT + 2);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  localparam logic [ROT_W-1:0] LAST = ROT_W'(STAGES - 1);
  localparam logic [LW-1:0] LAT_END = LW'(PIPE_LAT);
  logic [1:0] st, st_n;
  logic [ROT_W-1:0] stage, stage_n;
  logic [LW-1:0] lat, lat_n;
  logic pend, pend_n, ovr_n, drop, stage_end, eof, can_store;
`ifdef FFT_SCHED_PENDING_EN
  assign can_store = ~pend;
`else
  assign can_store = 1'b0;
`endif
  always_comb begin
    stage_end = st == WAIT && lat == LAT_END;
    eof = stage_end && stage == LAST;
    st_n = st;
    stage_n = stage;
    lat_n = lat;
    pend_n = pend;
    drop = 1'b0;
    if (st == IDLE && bus.frame_rdy) begin
      st_n = ISSUE;
      stage_n = '0;
    end else if (st == ISSUE) begin
      st_n = WAIT;
      lat_n = LW'(1);
    end else if (st == WAIT && !stage_end) begin
      lat_n = lat + LW'(1);
    end else if (st == WAIT && !eof) begin
      st_n = ISSUE;
      stage_n = stage + ROT_W'(1);
    end else if (eof) begin
      st_n = (pend || bus.frame_rdy) ? ISSUE : IDLE;
      stage_n = '0;
      pend_n = 1'b0;
      drop = pend && bus.frame_rdy;
    end
    // mid-frame arrivals: park in the slot if possible, otherwise lose them
    if (st != IDLE && !eof && bus.frame_rdy) begin
      pend_n = can_store ? 1'b1 : pend;
      drop = ~can_store;
    end
    ovr_n = drop | (bus.overrun & ~bus.ovr_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      stage <= '0;
      lat <= '0;
      pend <= 1'b0;
      bus.busy <= 1'b0;
      bus.rotation <= '0;
      bus.mux_flag <= 1'b0;
      bus.frame_ack <= 1'b0;
      bus.reg_load <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      st <= st_n;
      stage <= stage_n;
      lat <= lat_n;
      pend <= pend_n;
      bus.busy <= st_n != IDLE;
      bus.rotation <= st_n == IDLE ? '0 : stage_n;
      bus.mux_flag <= st_n != IDLE && stage_n == '0;
      bus.frame_ack <= st_n == ISSUE && stage_n == '0;
      bus.reg_load <= st_n == WAIT && lat_n == LAT_END && stage_n != LAST;
      bus.out_valid <= st_n == WAIT && lat_n == LAT_END && stage_n == LAST;
      bus.overrun <= ovr_n;
    end
  end
endmodule

// File: tb/tb_fft_stage_sched.sv
// tb_fft_stage_sched: directed per-cycle checks of fft_stage_sched (defaults and STAGES=4/PIPE_LAT=2).
module tb_fft_stage_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  fft_stage_sched_if #(.ROT_W(3)) b ();
  fft_stage_sched_if #(.ROT_W(3)) b2 ();
  fft_stage_sched #(.STAGES(3), .ROT_W(3), .PIPE_LAT(1)) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
  fft_stage_sched #(.STAGES(4), .ROT_W(3), .PIPE_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  always #5 clk = ~clk;
  // {frame_ack, mux_flag, rotation[2:0], reg_load, out_valid, busy, overrun} per cycle of one default frame
  localparam logic [8:0] FV [6] = '{9'b110000010, 9'b010001010, 9'b000010010,
                                    9'b000011010, 9'b000100010, 9'b000100110};
  localparam logic [8:0] F4 [14] = '{9'b000000000, 9'b110000010, 9'b010000010, 9'b010001010,
                                     9'b000010010, 9'b000010010, 9'b000011010, 9'b000100010,
                                     9'b000100010, 9'b000101010, 9'b000110010, 9'b000110010,
                                     9'b000110110, 9'b000000000};
  task automatic check(string tag, logic [8:0] got, logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask
  function automatic logic [8:0] obs();
    return {b.frame_ack, b.mux_flag, b.rotation, b.reg_load, b.out_valid, b.busy, b.overrun};
  endfunction
  function automatic logic [8:0] obs2();
    return {b2.frame_ack, b2.mux_flag, b2.rotation, b2.reg_load, b2.out_valid, b2.busy, b2.overrun};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic scen(string nm, logic [31:0] rdy, logic [31:0] clr, logic [31:0] starts,
                      int on, int off, int ra, int rb, int n);
    logic [8:0] want;
    rst_n = 1'b0;
    b.frame_rdy = 1'b0;
    b.ovr_clr = 1'b0;
    tick();
    tick();
    check({nm, " reset"}, obs(), 9'd0);
    rst_n = 1'b1;
    for (int c = 0; c < n; c++) begin
      tick();
      if (c >= ra && c < rb) begin
        rst_n = 1'b0;
        #1;
      end else rst_n = 1'b1;
      want = '0;
      for (int s = 0; s < 32; s++)
        if (starts[s] && c >= s && c < s + 6 && !(s < ra && c >= ra)) want |= FV[c-s];
      if (c >= on && c < off) want[0] = 1'b1;
      check($sformatf("%s c%0d", nm, c), obs(), want);
      b.frame_rdy = rdy[c];
      b.ovr_clr = clr[c];
    end
  endtask
  initial begin
    b.frame_rdy = 1'b0;
    b.ovr_clr = 1'b0;
    b2.frame_rdy = 1'b0;
    b2.ovr_clr = 1'b0;
    scen("single", 1 << 10, 0, 1 << 11, 99, 99, 99, 99, 20);
    scen("b2b", (1 << 10) | (1 << 16), 0, (1 << 11) | (1 << 17), 99, 99, 99, 99, 25);
`ifdef FFT_SCHED_PENDING_EN
    scen("pend", (1 << 10) | (1 << 13), 0, (1 << 11) | (1 << 17), 99, 99, 99, 99, 25);
    scen("pend_full", (1 << 10) | (1 << 12) | (1 << 14), 1 << 20, (1 << 11) | (1 << 17), 15, 21, 99, 99, 26);
    scen("eof_full", (1 << 10) | (1 << 12) | (1 << 16), 0, (1 << 11) | (1 << 17), 17, 99, 99, 99, 25);
    scen("set_wins", (1 << 10) | (1 << 12) | (1 << 14), 1 << 14, (1 << 11) | (1 << 17), 15, 99, 99, 99, 24);
`else
    scen("drop", (1 << 10) | (1 << 13), 0, 1 << 11, 14, 99, 99, 99, 25);
    scen("drop_clr", (1 << 10) | (1 << 12) | (1 << 14), 1 << 20, 1 << 11, 13, 21, 99, 99, 26);
    scen("eof_acc", (1 << 10) | (1 << 12) | (1 << 16), 0, (1 << 11) | (1 << 17), 13, 99, 99, 99, 25);
    scen("set_wins", (1 << 10) | (1 << 12) | (1 << 14), 1 << 14, 1 << 11, 13, 99, 99, 99, 24);
`endif
    scen("midrst", (1 << 10) | (1 << 20), 0, (1 << 11) | (1 << 21), 99, 99, 13, 15, 28);
    rst_n = 1'b0;
    tick();
    tick();
    check("s4 reset", obs2(), 9'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      check($sformatf("s4 c%0d", c), obs2(), F4[c]);
      b2.frame_rdy = (c == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
